// File: rtl/rca_lsq_pkg.sv
// rca_config: shared LSQ sizing, entry layout, funct3 codes and byte-enable helper.
package rca_config;
  localparam int XLEN = 32;
  localparam int LSQ_DEPTH = 4;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [2:0]      fn3;
    logic            is_store;
  } lsq_entry_t;
  function automatic logic [3:0] lane_be(input logic [2:0] f, input logic [1:0] lane);
    return f[1:0] == 2'b00 ? 4'b0001 << lane : f[1:0] == 2'b01 ? 4'b0011 << lane : 4'b1111;
  endfunction
endpackage

// File: rtl/rca_lsq_fifo.sv
// rca_lsq_fifo: circular entry FIFO with occupancy count; caller guards push/pop.
module rca_lsq_fifo
  import rca_config::*;
#(
  parameter int DEPTH = LSQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  lsq_entry_t             din,
  input  logic                   pop,
  output lsq_entry_t             head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);
  lsq_entry_t    r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  always_ff @(posedge clk)
    if (push) r_mem[r_wp] <= din;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + AW'(push);
      r_rp  <= r_rp + AW'(pop);
      r_cnt <= r_cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  assign head  = r_mem[r_rp];
  assign count = r_cnt;
  assign full  = r_cnt == (AW+1)'(DEPTH);
endmodule

// File: rtl/rca_lsq.sv
// rca_lsq: in-order load/store queue with a single-outstanding memory port.
// RCA_LSQ_MISALIGN_CHECK_EN rejects misaligned requests instead of masking the address.
module rca_lsq
  import rca_config::*;
#(
  parameter int DEPTH = LSQ_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      fn3,
  input  logic            load,
  input  logic            store,
  input  logic            new_request,
  output logic            lsq_full,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  output logic            mem_we,
  output logic            mem_req,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_rvalid,
  output logic [XLEN-1:0] load_data_out,
  output logic            load_data_valid,
  input  logic            load_data_ack,
  output logic            misalign_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESPOND} state_t;
  state_t                 r_state;
  lsq_entry_t             w_in, w_head;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_ok, w_push, w_pop, r_st;
  logic [2:0]             r_fn3;
  logic [1:0]             r_lane;
  logic [15:0]            w_sh;
  logic [XLEN-1:0]        w_ext;
  assign w_ok = new_request && !lsq_full && (load ^ store) &&
                (store ? fn3 inside {SB, SH, SW} : fn3 inside {LB, LH, LW, LBU, LHU});
`ifdef RCA_LSQ_MISALIGN_CHECK_EN
  logic w_mis, r_mis;
  assign w_mis  = (fn3[1:0] == 2'b01 && addr[0]) || (fn3[1:0] == 2'b10 && addr[1:0] != 2'b00);
  assign w_push = w_ok && !w_mis;
  assign w_in   = '{addr: addr, data: data, fn3: fn3, is_store: store};
  always_ff @(posedge clk)
    r_mis <= rst && w_ok && w_mis;
  assign misalign_err = r_mis;
`else
  assign w_push = w_ok;
  assign w_in   = '{addr: fn3[1:0] == 2'b10 ? {addr[XLEN-1:2], 2'b00} :
                          fn3[1:0] == 2'b01 ? {addr[XLEN-1:1], 1'b0} : addr,
                    data: data, fn3: fn3, is_store: store};
  assign misalign_err = 1'b0;
`endif
  assign w_pop = (r_state == ISSUE && mem_ack && r_st) || (r_state == WAIT_RD && mem_rvalid);
  rca_lsq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(w_push), .din(w_in), .pop(w_pop),
    .head(w_head), .count(w_count), .full(lsq_full)
  );
  assign w_sh  = 16'(mem_rdata >> {r_lane, 3'b000});
  assign w_ext = r_fn3 == LB  ? {{24{w_sh[7]}}, w_sh[7:0]} :
                 r_fn3 == LH  ? {{16{w_sh[15]}}, w_sh} :
                 r_fn3 == LBU ? {24'h0, w_sh[7:0]} :
                 r_fn3 == LHU ? {16'h0, w_sh} : mem_rdata;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state         <= IDLE;
      r_st            <= 1'b0;
      r_fn3           <= '0;
      r_lane          <= '0;
      mem_req         <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_be          <= '0;
      mem_we          <= 1'b0;
      load_data_out   <= '0;
      load_data_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_count != '0) begin
          r_st      <= w_head.is_store;
          r_fn3     <= w_head.fn3;
          r_lane    <= w_head.addr[1:0];
          mem_req   <= 1'b1;
          mem_addr  <= {w_head.addr[XLEN-1:2], 2'b00};
          mem_wdata <= w_head.data << {w_head.addr[1:0], 3'b000};
          mem_be    <= lane_be(w_head.fn3, w_head.addr[1:0]);
          mem_we    <= w_head.is_store;
          r_state   <= ISSUE;
        end
        ISSUE: if (mem_ack) begin
          mem_req <= 1'b0;
          r_state <= r_st ? IDLE : WAIT_RD;
        end
        WAIT_RD: if (mem_rvalid) begin
          load_data_out   <= w_ext;
          load_data_valid <= 1'b1;
          r_state         <= RESPOND;
        end
        default: if (load_data_ack) begin
          load_data_valid <= 1'b0;
          r_state         <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rca_lsq.sv
// tb_rca_lsq: directed vectors against hand-computed bus and load-result values.
module tb_rca_lsq;
  logic        clk = 0, rst = 0;
  logic [31:0] addr = 0, data = 0, mem_rdata = 0;
  logic [2:0]  fn3 = 0;
  logic        load = 0, store = 0, new_request = 0, mem_ack = 0, mem_rvalid = 0, load_data_ack = 0;
  logic        lsq_full, mem_we, mem_req, load_data_valid, misalign_err;
  logic [31:0] mem_addr, mem_wdata, load_data_out;
  logic [3:0]  mem_be;
  int          n_cmp = 0, n_bad = 0;

  rca_lsq dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .fn3(fn3), .load(load), .store(store),
    .new_request(new_request), .lsq_full(lsq_full), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_we(mem_we), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .load_data_out(load_data_out), .load_data_valid(load_data_valid),
    .load_data_ack(load_data_ack), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                      input logic ld, input logic st);
    addr = a; data = d; fn3 = f; load = ld; store = st; new_request = 1;
    @(negedge clk);
    new_request = 0; load = 0; store = 0;
  endtask

  task automatic wait_req(input string tag);
    int i = 0;
    while (!mem_req && i < 20) begin @(negedge clk); i++; end
    check({tag, " req"}, {31'h0, mem_req}, 1);
  endtask

  task automatic serve(input string tag, input logic [31:0] ea, input logic [3:0] ebe,
                       input logic ewe, input logic [31:0] ewd, input logic [31:0] rd,
                       input logic [31:0] eld);
    int i = 0;
    wait_req(tag);
    check({tag, " addr"}, mem_addr, ea);
    check({tag, " be"}, {28'h0, mem_be}, {28'h0, ebe});
    check({tag, " we"}, {31'h0, mem_we}, {31'h0, ewe});
    if (ewe) check({tag, " wdata"}, mem_wdata, ewd);
    @(negedge clk); mem_ack = 1;
    @(negedge clk); mem_ack = 0;
    if (!ewe) begin
      mem_rdata = rd; mem_rvalid = 1;
      @(negedge clk); mem_rvalid = 0;
      while (!load_data_valid && i < 20) begin @(negedge clk); i++; end
      check({tag, " ldv"}, {31'h0, load_data_valid}, 1);
      check({tag, " ld"}, load_data_out, eld);
      load_data_ack = 1;
      @(negedge clk); load_data_ack = 0;
    end
  endtask

  task automatic idle_for(input string tag, input int n);
    logic seen = 0;
    for (int i = 0; i < n; i++) begin @(negedge clk); seen |= mem_req | load_data_valid; end
    check({tag, " quiet"}, {31'h0, seen}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst req", {31'h0, mem_req}, 0);
    check("rst full", {31'h0, lsq_full}, 0);
    check("rst ldv", {31'h0, load_data_valid}, 0);
    check("rst be", {28'h0, mem_be}, 0);
    check("rst mis", {31'h0, misalign_err}, 0);
    rst = 1;
    @(negedge clk);

    push(32'h100, 32'hDEADBEEF, 3'b010, 0, 1);
    check("lat n+1", {31'h0, mem_req}, 0);
    @(negedge clk);
    check("lat n+2", {31'h0, mem_req}, 1);
    serve("sw", 32'h100, 4'b1111, 1, 32'hDEADBEEF, 0, 0);
    check("sw cnt", dut.w_count, 0);

    push(32'h103, 0, 3'b000, 1, 0);
    serve("lb", 32'h100, 4'b1000, 0, 0, 32'h80000000, 32'hFFFFFF80);
    push(32'h103, 0, 3'b100, 1, 0);
    serve("lbu", 32'h100, 4'b1000, 0, 0, 32'h80000000, 32'h00000080);
    push(32'h202, 32'h1234, 3'b001, 0, 1);
    serve("sh", 32'h200, 4'b1100, 1, 32'h12340000, 0, 0);
    push(32'h002, 0, 3'b001, 1, 0);
    serve("lh", 32'h000, 4'b1100, 0, 0, 32'h80010000, 32'hFFFF8001);
    push(32'h002, 0, 3'b101, 1, 0);
    serve("lhu", 32'h000, 4'b1100, 0, 0, 32'h80010000, 32'h00008001);
    push(32'h301, 32'h5A, 3'b000, 0, 1);
    serve("sb", 32'h300, 4'b0010, 1, 32'h00005A00, 0, 0);
    push(32'h300, 0, 3'b010, 1, 0);
    serve("lw", 32'h300, 4'b1111, 0, 0, 32'hCAFEF00D, 32'hCAFEF00D);

    push(32'h400, 0, 3'b010, 1, 1);
    push(32'h400, 0, 3'b010, 0, 0);
    push(32'h400, 0, 3'b100, 0, 1);
    push(32'h400, 0, 3'b011, 1, 0);
    check("drop cnt", dut.w_count, 0);
    idle_for("drop", 5);

    for (int i = 0; i < 4; i++) begin
      check("pre full", {31'h0, lsq_full}, 0);
      push(32'h10 + 4 * i, i, 3'b010, 0, 1);
    end
    check("full", {31'h0, lsq_full}, 1);
    push(32'h20, 32'h99, 3'b010, 0, 1);
    check("full cnt", dut.w_count, 4);
    repeat (3) @(negedge clk);
    check("hold addr", mem_addr, 32'h10);
    for (int i = 0; i < 4; i++)
      serve("fifo", 32'h10 + 4 * i, 4'b1111, 1, i, 0, 0);
    check("drain full", {31'h0, lsq_full}, 0);
    idle_for("drain", 5);

    push(32'h40, 0, 3'b010, 1, 0);
    push(32'h44, 7, 3'b010, 0, 1);
    wait_req("rstmid");
    check("rstmid addr", mem_addr, 32'h40);
    @(negedge clk); mem_ack = 1;
    @(negedge clk); mem_ack = 0; rst = 0;
    @(negedge clk); rst = 1;
    check("rstmid cnt", dut.w_count, 0);
    check("rstmid full", {31'h0, lsq_full}, 0);
    check("rstmid req", {31'h0, mem_req}, 0);
    mem_rdata = 32'h1; mem_rvalid = 1;
    @(negedge clk); mem_rvalid = 0;
    idle_for("rstmid", 6);

    push(32'h102, 0, 3'b010, 1, 0);
`ifdef RCA_LSQ_MISALIGN_CHECK_EN
    check("mis pulse", {31'h0, misalign_err}, 1);
    @(negedge clk);
    check("mis clear", {31'h0, misalign_err}, 0);
    idle_for("mis", 5);
`else
    check("mis tied", {31'h0, misalign_err}, 0);
    serve("lwmis", 32'h100, 4'b1111, 0, 0, 32'h11223344, 32'h11223344);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
